// File: rtl/systolic_tile_scheduler_if.sv
// Result port bundle for the tile scheduler.
// master drives res_valid/res_data, slave drives res_ready.
interface systolic_tile_scheduler_if #(
    parameter int data_width = 216
);
    logic                    res_valid;
    logic                    res_ready;
    logic [0:data_width-1]   res_data;

    modport master (
        output res_valid,
        output res_data,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        output res_ready
    );
endinterface

// File: rtl/systolic_tile_scheduler.sv
// Runs one systolic array over num_tiles K-tiles and sums the partial
// products into an accumulator bank, then offers the sum on res (valid/ready).
// Ports: clk, reset (sync, active-high), start, busy, tile_idx,
//   l_rd_addr/l_rd_data, t_rd_addr/t_rd_data (1-cycle read latency buffers),
//   sa_clear/sa_left/sa_top/sa_result (array side), res (result interface).
module systolic_tile_scheduler #(
    parameter int in_word_size  = 8,
    parameter int out_word_size = 24,
    parameter int num_row       = 3,
    parameter int num_col       = 3,
    parameter int tile_k        = 3,
    parameter int num_tiles     = 9,
    parameter int drain_cycles  = 8,
    parameter int addr_width    = 5
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    output logic                                      busy,
    output logic [$clog2(num_tiles):0]                tile_idx,
    output logic [addr_width-1:0]                     l_rd_addr,
    input  logic [in_word_size*num_row-1:0]           l_rd_data,
    output logic [addr_width-1:0]                     t_rd_addr,
    input  logic [in_word_size*num_col-1:0]           t_rd_data,
    output logic                                      sa_clear,
    output logic [in_word_size*num_row-1:0]           sa_left,
    output logic [in_word_size*num_col-1:0]           sa_top,
    input  logic [0:out_word_size*num_row*num_col-1]  sa_result,
    systolic_tile_scheduler_if.master                 res
);

    localparam int n_pe   = num_row * num_col;
    localparam int tile_w = $clog2(num_tiles) + 1;
    localparam int k_w    = $clog2(tile_k + 1);
    localparam int d_w    = $clog2(drain_cycles + 1);

    localparam logic [tile_w-1:0] tile_last = tile_w'(num_tiles - 1);
    localparam logic [k_w-1:0]    k_last    = k_w'(tile_k - 1);
    localparam logic [d_w-1:0]    d_last    = d_w'(drain_cycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        ACCUM,
        OUTPUT
    } state_t;

    state_t              state, state_n;
    logic [tile_w-1:0]   tile, tile_n;
    logic [k_w-1:0]      k, k_n;
    logic [d_w-1:0]      d, d_n;
    logic                acc_clr;
    logic                acc_add;
    logic                out_valid;
    logic [addr_width-1:0] base;
    logic [addr_width-1:0] rd_addr;

    logic [out_word_size-1:0]        acc [n_pe];
    logic [0:out_word_size*n_pe-1]   acc_flat;

    // First K index of the current tile in the operand buffers.
    assign base = addr_width'(32'(tile) * 32'(tile_k));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tile  <= '0;
            k     <= '0;
            d     <= '0;
        end else begin
            state <= state_n;
            tile  <= tile_n;
            k     <= k_n;
            d     <= d_n;
        end
    end

    always_comb begin
        state_n   = state;
        tile_n    = tile;
        k_n       = k;
        d_n       = d;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        out_valid = 1'b0;
        sa_clear  = 1'b0;
        sa_left   = '0;
        sa_top    = '0;
        rd_addr   = '0;
        unique case (state)
            IDLE: begin
                sa_clear = 1'b1;
                if (start) begin
                    state_n = CLEAR;
                    tile_n  = '0;
                    acc_clr = 1'b1;
                end
            end
            CLEAR: begin
                sa_clear = 1'b1;
                rd_addr  = base;
                state_n  = FEED;
                k_n      = '0;
            end
            FEED: begin
                // Read data lags its address by one cycle, so the
                // address presented here is for the next FEED cycle.
                sa_left = l_rd_data;
                sa_top  = t_rd_data;
                if (k != k_last) begin
                    rd_addr = base + addr_width'(k) + addr_width'(1);
                    k_n     = k + k_w'(1);
                end else begin
                    state_n = DRAIN;
                    d_n     = '0;
                end
            end
            DRAIN: begin
                if (d == d_last) begin
                    state_n = ACCUM;
                end else begin
                    d_n = d + d_w'(1);
                end
            end
            ACCUM: begin
                acc_add = 1'b1;
                state_n = CLEAR;
                if (tile == tile_last) begin
                    state_n = OUTPUT;
                end else begin
                    tile_n = tile + tile_w'(1);
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                sa_clear  = 1'b1;
                if (res.res_ready) begin
                    state_n = IDLE;
                    tile_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                tile_n  = '0;
            end
        endcase
    end

    // Sums wrap modulo 2^out_word_size.
    always_ff @(posedge clk) begin
        for (int i = 0; i < n_pe; i++) begin
            if (reset || acc_clr) begin
                acc[i] <= '0;
            end else if (acc_add) begin
                acc[i] <= acc[i]
                        + sa_result[i*out_word_size +: out_word_size];
            end
        end
    end

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < n_pe; i++) begin
            acc_flat[i*out_word_size +: out_word_size] = acc[i];
        end
    end

    assign busy          = (state != IDLE);
    assign tile_idx      = tile;
    assign l_rd_addr     = rd_addr;
    assign t_rd_addr     = rd_addr;
    assign res.res_valid = out_valid;
    assign res.res_data  = acc_flat;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench: two schedulers (24-bit and 16-bit results) in lockstep,
// each with its own behavioural array model and operand buffers.
module tb_systolic_tile_scheduler;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic res_ready;

    always #5 clk = ~clk;

    logic        busy1, busy2, clr1, clr2;
    logic [4:0]  tile1, tile2;
    logic [4:0]  la1, ta1, la2, ta2;
    logic [23:0] ld1, td1, ld2, td2;
    logic [23:0] sl1, st1, sl2, st2;
    logic [0:215] sr1;
    logic [0:143] sr2;
    logic [23:0] pe1 [9];
    logic [15:0] pe2 [9];
    logic [7:0]  lmem [32];
    logic [7:0]  tmem [32];
    logic [0:215] exp1;
    logic [0:143] exp2;

    int n_cmp = 0;
    int n_bad = 0;

    systolic_tile_scheduler_if #(.data_width(216)) r1 ();
    systolic_tile_scheduler_if #(.data_width(144)) r2 ();

    assign r1.res_ready = res_ready;
    assign r2.res_ready = res_ready;

    systolic_tile_scheduler dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1),
        .tile_idx(tile1), .l_rd_addr(la1), .l_rd_data(ld1),
        .t_rd_addr(ta1), .t_rd_data(td1), .sa_clear(clr1),
        .sa_left(sl1), .sa_top(st1), .sa_result(sr1), .res(r1)
    );

    systolic_tile_scheduler #(.out_word_size(16)) dut2 (
        .clk(clk), .reset(reset), .start(start), .busy(busy2),
        .tile_idx(tile2), .l_rd_addr(la2), .l_rd_data(ld2),
        .t_rd_addr(ta2), .t_rd_data(td2), .sa_clear(clr2),
        .sa_left(sl2), .sa_top(st2), .sa_result(sr2), .res(r2)
    );

    // Buffers: every lane of entry n holds lmem[n] / tmem[n].
    always_ff @(posedge clk) begin
        ld1 <= {3{lmem[la1]}};
        td1 <= {3{tmem[ta1]}};
        ld2 <= {3{lmem[la2]}};
        td2 <= {3{tmem[ta2]}};
    end

    // Array model: each PE accumulates left[r]*top[c] until cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (clr1) pe1[i] <= '0;
            else pe1[i] <= pe1[i] + 24'(sl1[(i/3)*8 +: 8]) * 24'(st1[(i%3)*8 +: 8]);
            if (clr2) pe2[i] <= '0;
            else pe2[i] <= pe2[i] + 16'(sl2[(i/3)*8 +: 8]) * 16'(st2[(i%3)*8 +: 8]);
        end
    end

    always_comb begin
        sr1 = '0;
        sr2 = '0;
        for (int i = 0; i < 9; i++) begin
            sr1[i*24 +: 24] = pe1[i];
            sr2[i*16 +: 16] = pe2[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int n = 0; n < 32; n++) begin
            lmem[n] = v;
            tmem[n] = v;
        end
    endtask

    task automatic fill_ramp();
        for (int n = 0; n < 32; n++) begin
            lmem[n] = 8'(n + 1);
            tmem[n] = 8'(n + 1);
        end
    endtask

    task automatic set_exp(input logic [23:0] v1, input logic [15:0] v2);
        for (int i = 0; i < 9; i++) begin
            exp1[i*24 +: 24] = v1;
            exp2[i*16 +: 16] = v2;
        end
    endtask

    // Returns with the start-sampling edge as edge 0.
    task automatic start_job();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges until res_valid; pulses start after edge `poke`.
    task automatic wait_valid(input int poke, output int e);
        e = 0;
        while (r1.res_valid !== 1'b1 && e < 300) begin
            tick();
            e++;
            start = (e == poke);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        fill_const(8'd0);
        repeat (3) tick();
        reset = 1'b0;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy1); end
        n_cmp++; if (clr1 !== 1'b1) begin n_bad++; $display("FAIL reset_clear: got %0b want 1", clr1); end
        n_cmp++; if (r1.res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", r1.res_valid); end
        n_cmp++; if (tile1 !== 5'd0) begin n_bad++; $display("FAIL reset_tile: got %0d want 0", tile1); end
        n_cmp++; if (la1 !== 5'd0 || ta1 !== 5'd0) begin n_bad++; $display("FAIL reset_addr: got %0d/%0d want 0/0", la1, ta1); end
        n_cmp++; if (sl1 !== 24'd0 || st1 !== 24'd0) begin n_bad++; $display("FAIL reset_sa: got %h/%h want 0/0", sl1, st1); end
    endtask

    task automatic test_all_ones();
        int e;
        fill_const(8'd1);
        set_exp(24'd27, 16'd27);
        res_ready = 1'b1;
        start_job();
        wait_valid(-1, e);
        n_cmp++; if (e !== 117) begin n_bad++; $display("FAIL ones_latency: got %0d want 117", e); end
        n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL ones_data: got %h want %h", r1.res_data, exp1); end
        n_cmp++; if (r2.res_data !== exp2) begin n_bad++; $display("FAIL ones_data16: got %h want %h", r2.res_data, exp2); end
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL ones_busy_out: got %0b want 1", busy1); end
        tick();
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL ones_busy_after: got %0b want 0", busy1); end
        n_cmp++; if (r1.res_valid !== 1'b0) begin n_bad++; $display("FAIL ones_valid_after: got %0b want 0", r1.res_valid); end
    endtask

    task automatic test_backpressure();
        int e;
        fill_const(8'd1);
        set_exp(24'd27, 16'd27);
        res_ready = 1'b0;
        start_job();
        wait_valid(-1, e);
        n_cmp++; if (e !== 117) begin n_bad++; $display("FAIL bp_latency: got %0d want 117", e); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++; if (r1.res_valid !== 1'b1 || busy1 !== 1'b1) begin n_bad++; $display("FAIL bp_hold_%0d: got valid %0b busy %0b want 1 1", c, r1.res_valid, busy1); end
            n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL bp_data_%0d: got %h want %h", c, r1.res_data, exp1); end
        end
        res_ready = 1'b1;
        tick();
        n_cmp++; if (r1.res_valid !== 1'b0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid %0b busy %0b want 0 0", r1.res_valid, busy1); end
    endtask

    task automatic test_addr_trace();
        int e;
        fill_ramp();
        set_exp(24'd6930, 16'd6930);
        res_ready = 1'b1;
        start_job();
        n_cmp++; if (la1 !== 5'd0 || ta1 !== 5'd0) begin n_bad++; $display("FAIL trace_clear_addr: got %0d/%0d want 0/0", la1, ta1); end
        for (int f = 0; f < 3; f++) begin
            tick();
            if (f < 2) begin
                n_cmp++; if (la1 !== 5'(f + 1) || ta1 !== 5'(f + 1)) begin n_bad++; $display("FAIL trace_feed%0d_addr: got %0d/%0d want %0d", f, la1, ta1, f + 1); end
            end
            n_cmp++; if (sl1[7:0] !== 8'(f + 1) || st1[23:16] !== 8'(f + 1)) begin n_bad++; $display("FAIL trace_feed%0d_data: got %h/%h want %0d", f, sl1, st1, f + 1); end
        end
        e = 3;
        while (r1.res_valid !== 1'b1 && e < 300) begin
            tick();
            e++;
            if (e >= 104 && e <= 106) begin
                n_cmp++; if (la1 !== 5'(e - 80) || ta1 !== 5'(e - 80)) begin n_bad++; $display("FAIL trace_t8_addr_%0d: got %0d/%0d want %0d", e, la1, ta1, e - 80); end
            end
            if (e == 104) begin
                n_cmp++; if (tile1 !== 5'd8) begin n_bad++; $display("FAIL trace_t8_tile: got %0d want 8", tile1); end
            end
        end
        n_cmp++; if (e !== 117) begin n_bad++; $display("FAIL trace_latency: got %0d want 117", e); end
        n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL trace_data: got %h want %h", r1.res_data, exp1); end
        tick();
    endtask

    task automatic test_start_ignored();
        int e;
        fill_const(8'd1);
        set_exp(24'd27, 16'd27);
        res_ready = 1'b0;
        start_job();
        wait_valid(27, e);
        n_cmp++; if (e !== 117) begin n_bad++; $display("FAIL ign_latency: got %0d want 117", e); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (r1.res_valid !== 1'b1 || tile1 !== 5'd8) begin n_bad++; $display("FAIL ign_output: got valid %0b tile %0d want 1 8", r1.res_valid, tile1); end
        n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL ign_data: got %h want %h", r1.res_data, exp1); end
        res_ready = 1'b1;
        tick();
        n_cmp++; if (busy1 !== 1'b0 || tile1 !== 5'd0) begin n_bad++; $display("FAIL ign_idle: got busy %0b tile %0d want 0 0", busy1, tile1); end
        n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL ign_retain: got %h want %h", r1.res_data, exp1); end
    endtask

    task automatic test_back_to_back();
        int e;
        fill_const(8'd1);
        set_exp(24'd27, 16'd27);
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        tick();
        e = 0;
        while (r1.res_valid !== 1'b1 && e < 300) begin
            tick();
            e++;
        end
        n_cmp++; if (e !== 117) begin n_bad++; $display("FAIL b2b_latency1: got %0d want 117", e); end
        tick();
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %0b want 0", busy1); end
        tick();
        start = 1'b0;
        n_cmp++; if (busy1 !== 1'b1 || tile1 !== 5'd0) begin n_bad++; $display("FAIL b2b_restart: got busy %0b tile %0d want 1 0", busy1, tile1); end
        wait_valid(-1, e);
        n_cmp++; if (e !== 117) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 117", e); end
        n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL b2b_data: got %h want %h", r1.res_data, exp1); end
        tick();
    endtask

    task automatic test_wrap();
        int e;
        fill_const(8'hFF);
        set_exp(24'h1ACA1B, 16'hCA1B);
        res_ready = 1'b1;
        start_job();
        wait_valid(-1, e);
        n_cmp++; if (r2.res_data !== exp2) begin n_bad++; $display("FAIL wrap_data16: got %h want %h", r2.res_data, exp2); end
        n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL wrap_data24: got %h want %h", r1.res_data, exp1); end
        tick();
    endtask

    task automatic test_reset_output();
        int e;
        fill_const(8'd1);
        res_ready = 1'b0;
        start_job();
        wait_valid(-1, e);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_cmp++; if (r1.res_valid !== 1'b0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL rstout_state: got valid %0b busy %0b want 0 0", r1.res_valid, busy1); end
        n_cmp++; if (clr1 !== 1'b1 || tile1 !== 5'd0) begin n_bad++; $display("FAIL rstout_clear: got clear %0b tile %0d want 1 0", clr1, tile1); end
        n_cmp++; if (sl1 !== 24'd0 || st1 !== 24'd0) begin n_bad++; $display("FAIL rstout_sa: got %h/%h want 0/0", sl1, st1); end
        res_ready = 1'b1;
    endtask

    task automatic test_midjob_reset();
        int e;
        fill_const(8'hFF);
        res_ready = 1'b1;
        start_job();
        repeat (54) tick();
        n_cmp++; if (tile1 !== 5'd4 || sl1[7:0] !== 8'hFF) begin n_bad++; $display("FAIL mid_pos: got tile %0d left %h want 4 ff", tile1, sl1[7:0]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (busy1 !== 1'b0 || sl1 !== 24'd0) begin n_bad++; $display("FAIL mid_abort: got busy %0b left %h want 0 0", busy1, sl1); end
        fill_const(8'd1);
        set_exp(24'd27, 16'd27);
        start_job();
        wait_valid(-1, e);
        n_cmp++; if (e !== 117) begin n_bad++; $display("FAIL mid_latency: got %0d want 117", e); end
        n_cmp++; if (r1.res_data !== exp1) begin n_bad++; $display("FAIL mid_data: got %h want %h", r1.res_data, exp1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_backpressure();
        test_addr_trace();
        test_start_ignored();
        test_back_to_back();
        test_wrap();
        test_reset_output();
        test_midjob_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
